// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand selection and writeback bypass
module id_ex_stage #(
  parameter int XLEN    = 64,
  parameter int ALUOP_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [4:0]         in_rs1_idx,
  input  logic [4:0]         in_rs2_idx,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [1:0]         in_op1_sel,
  input  logic [1:0]         in_op2_sel,
  input  logic [ALUOP_W-1:0] in_alu_op,
  input  logic [4:0]         in_rd,
  input  logic               in_rd_wen,
  input  logic               wb_wen,
  input  logic [4:0]         wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    operator_1,
  output logic [XLEN-1:0]    operator_2,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [XLEN-1:0]    out_pc,
  output logic [4:0]         out_rd,
  output logic               out_rd_wen
);

  localparam logic [1:0]      SEL_RS   = 2'd0;
  localparam logic [1:0]      SEL_ALT  = 2'd1;
  localparam logic [1:0]      SEL_FOUR = 2'd2;
  localparam logic [XLEN-1:0] LP_FOUR  = XLEN'(4);

  logic               r_valid;
  logic [XLEN-1:0]    r_op1;
  logic [XLEN-1:0]    r_op2;
  logic [ALUOP_W-1:0] r_alu_op;
  logic [XLEN-1:0]    r_pc;
  logic [4:0]         r_rd;
  logic               r_rd_wen;
  logic [4:0]         r_rs1_idx;
  logic [4:0]         r_rs2_idx;
  logic [1:0]         r_op1_sel;
  logic [1:0]         r_op2_sel;

  logic               w_out_fire;
  logic               w_capture;
  logic               w_hold;
  logic               w_wb_hit1;
  logic               w_wb_hit2;
  logic [XLEN-1:0]    w_rs1_val;
  logic [XLEN-1:0]    w_rs2_val;
  logic [XLEN-1:0]    w_op1;
  logic [XLEN-1:0]    w_op2;

  // Reset forces ready high; an incoming instruction is dropped by reset anyway.
  assign in_ready   = ~r_valid | out_ready | reset;
  assign w_out_fire = r_valid & out_ready;
  assign w_capture  = in_valid & in_ready & ~flush;
  assign w_hold     = r_valid & ~out_ready & ~flush;

  // Writeback hit against the stored source indices (x0 never forwards).
  assign w_wb_hit1 = wb_wen & (wb_rd != 5'd0) & (wb_rd == r_rs1_idx) & (r_op1_sel == SEL_RS);
  assign w_wb_hit2 = wb_wen & (wb_rd != 5'd0) & (wb_rd == r_rs2_idx) & (r_op2_sel == SEL_RS);

  // Capture-time bypass followed by operand selection.
  always_comb begin
    w_rs1_val = in_rs1_data;
    w_rs2_val = in_rs2_data;
    if (wb_wen && (in_rs1_idx != 5'd0) && (wb_rd == in_rs1_idx)) w_rs1_val = wb_data;
    if (wb_wen && (in_rs2_idx != 5'd0) && (wb_rd == in_rs2_idx)) w_rs2_val = wb_data;

    w_op1 = '0;
    case (in_op1_sel)
      SEL_RS:  w_op1 = w_rs1_val;
      SEL_ALT: w_op1 = in_pc;
      default: w_op1 = '0;
    endcase

    w_op2 = '0;
    case (in_op2_sel)
      SEL_RS:   w_op2 = w_rs2_val;
      SEL_ALT:  w_op2 = in_imm;
      SEL_FOUR: w_op2 = LP_FOUR;
      default:  w_op2 = '0;
    endcase
  end

  // Entry valid bit: reset, then flush, then capture, then drain.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  // Entry payload: load on capture, patch operands from writeback while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op1     <= '0;
      r_op2     <= '0;
      r_alu_op  <= '0;
      r_pc      <= '0;
      r_rd      <= '0;
      r_rd_wen  <= 1'b0;
      r_rs1_idx <= '0;
      r_rs2_idx <= '0;
      r_op1_sel <= '0;
      r_op2_sel <= '0;
    end else if (w_capture) begin
      r_op1     <= w_op1;
      r_op2     <= w_op2;
      r_alu_op  <= in_alu_op;
      r_pc      <= in_pc;
      r_rd      <= in_rd;
      r_rd_wen  <= in_rd_wen;
      r_rs1_idx <= in_rs1_idx;
      r_rs2_idx <= in_rs2_idx;
      r_op1_sel <= in_op1_sel;
      r_op2_sel <= in_op2_sel;
    end else if (w_hold) begin
      if (w_wb_hit1) r_op1 <= wb_data;
      if (w_wb_hit2) r_op2 <= wb_data;
    end
  end

  assign out_valid  = r_valid;
  assign operator_1 = r_op1;
  assign operator_2 = r_op2;
  assign alu_op     = r_alu_op;
  assign out_pc     = r_pc;
  assign out_rd     = r_rd;
  assign out_rd_wen = r_rd_wen;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage with random and directed stimulus
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, in_rd_wen, wb_wen, flush, out_valid, out_ready, out_rd_wen;
  logic [63:0] in_pc, in_rs1_data, in_rs2_data, in_imm, wb_data;
  logic [63:0] operator_1, operator_2, out_pc;
  logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd, wb_rd, out_rd;
  logic [1:0]  in_op1_sel, in_op2_sel;
  logic [5:0]  in_alu_op, alu_op;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    logic        v;
    logic [63:0] op1, op2, pc;
    logic [5:0]  alu;
    logic [4:0]  rd;
    logic        wen;
  } snap_t;

  snap_t exp_q[$];

  // reference model state: what the stage should hold right now
  logic        m_v;
  logic [63:0] m_op1, m_op2, m_pc;
  logic [5:0]  m_alu;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic        m_wen;
  logic [1:0]  m_s1, m_s2;

  always #5 clock = ~clock;

  id_ex_stage #(.XLEN(64), .ALUOP_W(6)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel), .in_alu_op(in_alu_op),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .operator_1(operator_1), .operator_2(operator_2), .alu_op(alu_op),
    .out_pc(out_pc), .out_rd(out_rd), .out_rd_wen(out_rd_wen)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [63:0] src_val(input logic [4:0] idx, input logic [63:0] rf);
    if (idx != 0 && wb_wen && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  // Advance one clock: model consumes the inputs seen at the edge and queues the expected outputs.
  task automatic step();
    snap_t s;
    @(posedge clock);
    if (reset) begin
      m_v = 0; m_op1 = 0; m_op2 = 0; m_pc = 0; m_alu = 0; m_rd = 0; m_wen = 0;
      m_rs1 = 0; m_rs2 = 0; m_s1 = 0; m_s2 = 0;
    end else if (flush) begin
      m_v = 0;
    end else if (in_valid && (!m_v || out_ready)) begin
      m_op1 = (in_op1_sel == 0) ? src_val(in_rs1_idx, in_rs1_data) : (in_op1_sel == 1) ? in_pc : 64'd0;
      m_op2 = (in_op2_sel == 0) ? src_val(in_rs2_idx, in_rs2_data) : (in_op2_sel == 1) ? in_imm
            : (in_op2_sel == 2) ? 64'd4 : 64'd0;
      m_pc = in_pc; m_alu = in_alu_op; m_rd = in_rd; m_wen = in_rd_wen;
      m_rs1 = in_rs1_idx; m_rs2 = in_rs2_idx; m_s1 = in_op1_sel; m_s2 = in_op2_sel;
      m_v = 1;
    end else if (m_v && out_ready) begin
      m_v = 0;
    end else if (m_v && wb_wen && wb_rd != 0) begin
      if (wb_rd == m_rs1 && m_s1 == 0) m_op1 = wb_data;
      if (wb_rd == m_rs2 && m_s2 == 0) m_op2 = wb_data;
    end
    s.v = m_v; s.op1 = m_op1; s.op2 = m_op2; s.pc = m_pc; s.alu = m_alu; s.rd = m_rd; s.wen = m_wen;
    exp_q.push_back(s);
    #1;
  endtask

  task automatic check_snap(input snap_t s);
    chk("out_valid", {63'd0, out_valid}, {63'd0, s.v});
    chk("in_ready", {63'd0, in_ready}, {63'd0, reset | ~s.v | out_ready});
    chk("operator_1", operator_1, s.op1);
    chk("operator_2", operator_2, s.op2);
    chk("out_pc", out_pc, s.pc);
    chk("alu_op", {58'd0, alu_op}, {58'd0, s.alu});
    chk("out_rd", {59'd0, out_rd}, {59'd0, s.rd});
    chk("out_rd_wen", {63'd0, out_rd_wen}, {63'd0, s.wen});
  endtask

  // Monitor: every output sample away from the edge is compared with the oldest expectation.
  always @(negedge clock) begin
    if (exp_q.size() != 0) check_snap(exp_q.pop_front());
  end

  task automatic idle_inputs();
    in_valid = 0; in_pc = 0; in_rs1_idx = 0; in_rs2_idx = 0; in_rs1_data = 0; in_rs2_data = 0;
    in_imm = 0; in_op1_sel = 0; in_op2_sel = 0; in_alu_op = 0; in_rd = 0; in_rd_wen = 0;
    wb_wen = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic rand_inputs();
    in_valid    = ($urandom_range(0, 3) != 0);
    out_ready   = ($urandom_range(0, 4) < 3);
    flush       = ($urandom_range(0, 19) == 0);
    reset       = ($urandom_range(0, 49) == 0);
    in_pc       = {$urandom, $urandom};
    in_rs1_idx  = 5'($urandom_range(0, 7));
    in_rs2_idx  = 5'($urandom_range(0, 7));
    in_rs1_data = {$urandom, $urandom};
    in_rs2_data = {$urandom, $urandom};
    in_imm      = {$urandom, $urandom};
    in_op1_sel  = 2'($urandom_range(0, 3));
    in_op2_sel  = 2'($urandom_range(0, 3));
    in_alu_op   = 6'($urandom_range(0, 63));
    in_rd       = 5'($urandom_range(0, 31));
    in_rd_wen   = 1'($urandom_range(0, 1));
    wb_wen      = 1'($urandom_range(0, 1));
    wb_rd       = 5'($urandom_range(0, 7));
    wb_data     = {$urandom, $urandom};
  endtask

  initial begin
    logic [63:0] held_pc;
    idle_inputs();
    out_ready = 0;
    reset = 1;
    step(); step();
    @(negedge clock);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    reset = 0;
    step();

    // capture with pc / imm selection
    in_valid = 1; out_ready = 1; in_op1_sel = 1; in_op2_sel = 1; in_pc = 64'h8000_0000; in_imm = 64'h10;
    step();
    @(negedge clock);
    chk("cap_valid", {63'd0, out_valid}, 64'd1);
    chk("cap_op1", operator_1, 64'h8000_0000);
    chk("cap_op2", operator_2, 64'h10);

    // capture bypass, then x0 never forwards
    in_op1_sel = 0; in_rs1_idx = 5; in_rs1_data = 64'h1; wb_wen = 1; wb_rd = 5; wb_data = 64'hABCD;
    step();
    @(negedge clock);
    chk("cap_bypass_op1", operator_1, 64'hABCD);
    in_rs1_idx = 0; wb_rd = 0;
    step();
    @(negedge clock);
    chk("cap_x0_op1", operator_1, 64'h1);
    idle_inputs();
    step();

    // held bypass on rs2
    out_ready = 0; in_valid = 1; in_rs2_idx = 7; in_op2_sel = 0; in_rs2_data = 64'h3; in_pc = 64'h2000;
    step();
    in_valid = 0; wb_wen = 1; wb_rd = 7; wb_data = 64'h55;
    step();
    @(negedge clock);
    chk("held_bypass_op2", operator_2, 64'h55);
    chk("held_bypass_pc", out_pc, 64'h2000);
    wb_wen = 0; out_ready = 1;
    step();
    out_ready = 0; in_valid = 1; in_op2_sel = 1; in_imm = 64'h99;
    step();
    in_valid = 0; wb_wen = 1; wb_rd = 7; wb_data = 64'h77;
    step();
    @(negedge clock);
    chk("held_imm_op2", operator_2, 64'h99);
    idle_inputs(); out_ready = 1;
    step();

    // back-to-back throughput
    in_valid = 1; out_ready = 1; in_op1_sel = 1;
    for (int i = 0; i < 8; i++) begin
      in_pc = 64'h1000 + 64'(4 * i);
      step();
      @(negedge clock);
      chk("tput_valid", {63'd0, out_valid}, 64'd1);
      chk("tput_pc", out_pc, 64'h1000 + 64'(4 * i));
    end
    in_valid = 0;
    step();

    // flush while stalled kills held and incoming
    out_ready = 0; in_valid = 1; in_pc = 64'h3000;
    step();
    held_pc = 64'h3000;
    flush = 1; in_pc = 64'hDEAD;
    step();
    @(negedge clock);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_no_capture_pc", out_pc, held_pc);
    flush = 0; in_valid = 0;
    step();

    // reset mid-stall, overriding flush and capture
    in_valid = 1; in_op1_sel = 1; in_pc = 64'h4000;
    step();
    reset = 1; flush = 1; in_pc = 64'h5000;
    step();
    @(negedge clock);
    chk("rst_stall_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_stall_op1", operator_1, 64'd0);
    chk("rst_stall_pc", out_pc, 64'd0);
    chk("rst_stall_in_ready", {63'd0, in_ready}, 64'd1);
    reset = 0; flush = 0; in_valid = 0;
    step();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    idle_inputs(); reset = 0; out_ready = 1;
    step(); step();
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
